// File: rtl/apb_timer_if.sv
// APB bus bundle between a requester and the apb_timer completer.
// Ports: PSEL/PENABLE/PWRITE/PADDR/PWDATA from requester; PRDATA/PREADY/PSLVERR from completer.
// Modports: master (requester side), slave (completer side).
interface apb_timer_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_timer.sv
// Purpose: APB down-counting timer with 8-bit prescaler, auto-reload and level IRQ.
// Latency: every APB transfer takes exactly one wait state; PRDATA/PSLVERR registered.
// Backpressure: PREADY is low in the first access cycle, high in the second, never longer.
// Ports: PCLK clock, PRESET async active-high reset, apb (slave modport of apb_timer_if),
//        IRQ = STATUS.EXP & CTRL.IRQ_EN.
module apb_timer (
  input  logic       PCLK,
  input  logic       PRESET,
  apb_timer_if.slave apb,
  output logic       IRQ
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [4:0] A_CTRL     = 5'h00;
  localparam logic [4:0] A_LOAD     = 5'h04;
  localparam logic [4:0] A_COUNT    = 5'h08;
  localparam logic [4:0] A_STATUS   = 5'h0C;
  localparam logic [4:0] A_PRESCALE = 5'h10;

  // Bus-side registers
  state_t      state_q;
  logic [31:0] prdata_q;
  logic        pready_q;
  logic        pslverr_q;

  // Timer registers
  logic        en_q, en_d;
  logic        auto_q, auto_d;
  logic        irq_en_q, irq_en_d;
  logic [31:0] load_q, load_d;
  logic [31:0] count_q, count_d;
  logic        exp_q, exp_d;
  logic [7:0]  presc_q, presc_d;
  logic [7:0]  psc_q, psc_d;

  logic [4:0]  addr;
  logic        addr_ok;
  logic [31:0] rd_val;
  logic        commit;
  logic        wr_ctrl, wr_load, wr_status, wr_presc;
  logic        tick;
  logic        exp_set;

  // Only PADDR[4:0] is decoded.
  logic unused_paddr;
  assign unused_paddr = ^apb.PADDR[31:5];

  assign addr = apb.PADDR[4:0];

  always_comb begin
    addr_ok = 1'b1;
    rd_val  = '0;
    case (addr)
      A_CTRL:     rd_val = {29'd0, irq_en_q, auto_q, en_q};
      A_LOAD:     rd_val = load_q;
      A_COUNT:    rd_val = count_q;
      A_STATUS:   rd_val = {31'd0, exp_q};
      A_PRESCALE: rd_val = {24'd0, presc_q};
      default:    addr_ok = 1'b0;
    endcase
  end

  // The write lands on the edge that leaves WAIT. An erroring transfer never writes,
  // and a requester that has already dropped PSEL gets its write discarded.
  assign commit    = (state_q == WAIT) && apb.PSEL && apb.PENABLE && apb.PWRITE && !pslverr_q;
  assign wr_ctrl   = commit && (addr == A_CTRL);
  assign wr_load   = commit && (addr == A_LOAD);
  assign wr_status = commit && (addr == A_STATUS);
  assign wr_presc  = commit && (addr == A_PRESCALE);

  assign tick    = en_q && (psc_q == presc_q);
  assign exp_set = tick && (count_q == '0);

  always_comb begin
    en_d     = en_q;
    auto_d   = auto_q;
    irq_en_d = irq_en_q;
    load_d   = load_q;
    count_d  = count_q;
    presc_d  = presc_q;
    psc_d    = psc_q;

    // Prescaler holds its value while the timer is disabled.
    if (tick) begin
      psc_d = '0;
    end else if (en_q) begin
      psc_d = psc_q + 8'd1;
    end

    if (tick) begin
      if (count_q != '0) begin
        count_d = count_q - 32'd1;
      end else if (auto_q) begin
        count_d = load_q;
      end else begin
        en_d = 1'b0;
      end
    end

    // Software writes come after the hardware updates so they take priority.
    if (wr_ctrl) begin
      en_d     = apb.PWDATA[0];
      auto_d   = apb.PWDATA[1];
      irq_en_d = apb.PWDATA[2];
      if (apb.PWDATA[0] && !en_q) begin
        psc_d = '0;
      end
    end
    if (wr_load) begin
      load_d  = apb.PWDATA;
      count_d = apb.PWDATA;
      psc_d   = '0;
    end
    if (wr_presc) begin
      presc_d = apb.PWDATA[7:0];
    end

    // A hardware expiry in the same cycle as a W1C keeps EXP set.
    exp_d = (exp_q & ~(wr_status & apb.PWDATA[0])) | exp_set;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      en_q     <= 1'b0;
      auto_q   <= 1'b0;
      irq_en_q <= 1'b0;
      load_q   <= '0;
      count_q  <= '0;
      exp_q    <= 1'b0;
      presc_q  <= '0;
      psc_q    <= '0;
    end else begin
      en_q     <= en_d;
      auto_q   <= auto_d;
      irq_en_q <= irq_en_d;
      load_q   <= load_d;
      count_q  <= count_d;
      exp_q    <= exp_d;
      presc_q  <= presc_d;
      psc_q    <= psc_d;
    end
  end

  // Handshake FSM. Read data and error are captured on entry to WAIT and
  // cleared on the way out, so they are zero outside WAIT.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (apb.PSEL && apb.PENABLE) begin
            state_q   <= WAIT;
            pready_q  <= 1'b1;
            pslverr_q <= !addr_ok;
            prdata_q  <= (addr_ok && !apb.PWRITE) ? rd_val : '0;
          end
        end
        WAIT: begin
          state_q   <= IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
        end
        default: begin
          state_q   <= IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
        end
      endcase
    end
  end

  assign apb.PRDATA  = prdata_q;
  assign apb.PREADY  = pready_q;
  assign apb.PSLVERR = pslverr_q;
  assign IRQ         = exp_q & irq_en_q;

endmodule

// File: doc/apb_timer.md
APB_TIMER -- requirements
Module: apb_timer

Interface
REQ-001 Port list SHALL be:
  PCLK     in   1   sole clock; all state updates on rising edge
  PRESET   in   1   reset, asynchronous, active-high
  PSEL     in   1   APB select
  PENABLE  in   1   APB access phase
  PWRITE   in   1   1 = write, 0 = read
  PADDR    in   32  byte address; bits [4:0] decoded
  PWDATA   in   32  write data
  PRDATA   out  32  read data, registered
  PREADY   out  1   transfer complete, registered
  PSLVERR  out  1   error response, registered
  IRQ      out  1   timer interrupt, level, active-high
REQ-002 One clock (PCLK); reset SHALL be asynchronous, active-high (PRESET).
REQ-003 Block SHALL be an APB completer (responder) with exactly one wait state per transfer.

Function
REQ-004 Register map (PADDR[4:0], word-aligned) SHALL be:
  0x00 CTRL: [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN; RW; other bits read 0.
  0x04 LOAD: 32-bit, RW.
  0x08 COUNT: 32-bit, RO; writes ignored, no error.
  0x0C STATUS: [0] EXP; W1C.
  0x10 PRESCALE: [7:0], RW.
REQ-005 Any other offset, including unaligned PADDR[1:0]!=0, SHALL complete with PSLVERR=1, PRDATA=0, no register change.
REQ-006 Handshake FSM states SHALL be IDLE and WAIT.
REQ-007 IDLE -> WAIT when PSEL&PENABLE; in IDLE, PREADY=0.
REQ-008 In WAIT, PREADY=1, PRDATA/PSLVERR valid; write SHALL commit at the edge leaving WAIT; WAIT -> IDLE unconditionally.
REQ-009 PRDATA and PSLVERR SHALL be captured on the IDLE->WAIT edge; outside WAIT, PRDATA=0 and PSLVERR=0.
REQ-010 If PSEL drops while in WAIT, FSM SHALL still return to IDLE and discard the write.
REQ-011 Prescaler: 8-bit counter; tick when EN=1 and prescaler==PRESCALE, prescaler then clears; PRESCALE=0 gives a tick every cycle.
REQ-012 On tick with COUNT!=0, COUNT SHALL decrement by 1.
REQ-013 On tick with COUNT==0: EXP<=1; if AUTO_RELOAD, COUNT<=LOAD; else EN<=0 and COUNT stays 0.
REQ-014 Write to LOAD SHALL also set COUNT<=PWDATA and clear the prescaler.
REQ-015 CTRL write with EN 0->1 SHALL clear the prescaler.
REQ-016 EXP set by hardware in the same cycle as a W1C clear: set SHALL win.
REQ-017 LOAD write in the same cycle as a tick: the LOAD write SHALL win.
REQ-018 IRQ SHALL equal EXP & IRQ_EN, combinational from registers.

Reset
REQ-019 PRESET=1 SHALL immediately force state IDLE and clear CTRL, LOAD, COUNT, STATUS, PRESCALE and the prescaler.
REQ-020 PRESET=1 SHALL drive PRDATA=0, PREADY=0, PSLVERR=0 and IRQ=0.
REQ-021 Reset asserted mid-transfer SHALL abort the transfer with no register update.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
  - Write LOAD=5, then read COUNT -> PREADY is high in the 2nd access cycle only; PRDATA=5, PSLVERR=0.
  - LOAD=3, PRESCALE=0, CTRL=0x5 -> COUNT 3,2,1,0 on consecutive cycles; next cycle EXP=1, IRQ=1, EN=0.
  - AUTO_RELOAD=1, LOAD=2, PRESCALE=1 -> COUNT steps every 2 cycles; reloads to 2 on expiry; EXP stays set until W1C of 0x1.
  - Read 0x14 and write 0x02 -> PSLVERR=1, PRDATA=0, no register changes.
  - W1C STATUS in the same cycle as an expiry -> EXP remains 1.
  - PRESET asserted during WAIT of a LOAD write -> LOAD=0 and PREADY=0 immediately.
